// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Next-fetch-PC predictor and EX-stage redirect unit for the five-stage CPU.
//   There are four strategies: static not-taken, static taken through a BTB,
//   delay slot, and dynamic bimodal using 2-bit saturating counters.
//   The unit also keeps saturating counts of resolved branches and of
//   mispredictions.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   mode              00 not-taken, 01 static taken, 10 delay slot, 11 bimodal
//   if_pc             current fetch PC
//   pred_taken        combinational prediction for if_pc
//   pred_target       BTB target for if_pc (0 on miss)
//   next_pc           PC the PC register loads at the next edge
//   ex_*              branch/jump resolution from EX, with the prediction
//                     that travelled down the pipe
//   flush_if/flush_id kill IF/ID and ID/EX contents on a mispredict
//   branch_count      resolved branches and jumps (saturating)
//   mispredict_count  mispredictions (saturating)
module branch_predict_unit #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned PC_W     = 32,
  parameter logic [1:0]  CTR_INIT = 2'b10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic [PC_W-1:0] next_pc,
  input  logic            ex_valid,
  input  logic            ex_is_jump,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            flush_if,
  output logic            flush_id,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  typedef enum logic [1:0] {
    MODE_NT  = 2'b00,
    MODE_BTB = 2'b01,
    MODE_DS  = 2'b10,
    MODE_BIM = 2'b11
  } mode_e;

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  // BTB storage
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [PC_W-1:0]  target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  // Fetch-side lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  // Resolve-side lookup
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Low PC bits are always zero for word-aligned instructions.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  logic            mispredict;
  logic [PC_W-1:0] correction_pc;

  always_comb begin
    unique case (mode_s)
      MODE_BTB: pred_taken = if_hit;
      MODE_BIM: pred_taken = if_hit && ctr_q[if_idx][1];
      default:  pred_taken = 1'b0;
    endcase
    pred_target = if_hit ? target_q[if_idx] : '0;

    // While reset is held, redirect requests from EX are ignored.
    mispredict = rst && ex_valid &&
                 ((ex_pred_taken != ex_taken) ||
                  (ex_taken && (ex_pred_target != ex_target)));

    if (ex_taken)
      correction_pc = ex_target;
    else if (mode_s == MODE_DS)
      correction_pc = ex_pc + PC_W'(8);
    else
      correction_pc = ex_pc + PC_W'(4);

    if (mispredict)
      next_pc = correction_pc;
    else if (pred_taken)
      next_pc = pred_target;
    else
      next_pc = if_pc + PC_W'(4);

    flush_if = mispredict;
    flush_id = mispredict && (mode_s != MODE_DS);
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;

    if (ex_valid && (mode_s == MODE_BTB || mode_s == MODE_BIM)) begin
      if (ex_taken) begin
        if (ex_hit) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'b01;
          target_d[ex_idx] = ex_target;
        end else begin
          valid_d[ex_idx]  = 1'b1;
          tag_d[ex_idx]    = ex_tag;
          target_d[ex_idx] = ex_target;
          ctr_d[ex_idx]    = ex_is_jump ? 2'b11 : CTR_INIT;
        end
      end else if (ex_hit) begin
        if (ctr_q[ex_idx] != 2'b00) ctr_d[ex_idx] = ctr_q[ex_idx] - 2'b01;
      end
    end

    branch_count_d = branch_count_q;
    if (ex_valid && (branch_count_q != '1))
      branch_count_d = branch_count_q + 32'd1;

    mispredict_count_d = mispredict_count_q;
    if (mispredict && (mispredict_count_q != '1))
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      ctr_q              <= ctr_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch prediction and redirect unit for the five-stage pipelined CPU. It replaces the fixed 2-bit strategy select with four modes: static not-taken, static taken via a branch target buffer, delay slot, and dynamic bimodal. It sits beside the IF stage to supply the next fetch PC, and takes branch/jump resolution from EX to produce flush and redirect signals. It also keeps branch and mispredict statistics.

## Interface
- ENTRIES, 16: BTB entries; power of 2, ≥2. IDX_W = log2(ENTRIES).
- PC_W, 32: PC width. Tag = pc[PC_W-1:IDX_W+2].
- CTR_INIT, 2'b10: counter value for a newly allocated conditional-branch entry.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- mode  in  2  00 not-taken, 01 static taken (BTB hit), 10 delay slot, 11 bimodal.
- if_pc  in  PC_W  current fetch PC.
- pred_taken  out  1  prediction for if_pc (combinational).
- pred_target  out  PC_W  BTB target for if_pc (0 on miss).
- next_pc  out  PC_W  PC to load into the PC register at the next edge.
- ex_valid  in  1  branch or jump resolving in EX this cycle.
- ex_is_jump  in  1  1 = unconditional j, 0 = conditional beq.
- ex_pc  in  PC_W  PC of the resolving instruction.
- ex_taken  in  1  actual outcome.
- ex_target  in  PC_W  actual target.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  PC_W  predicted target carried down the pipe.
- flush_if  out  1  kill the instruction in IF/ID.
- flush_id  out  1  kill the instruction in ID/EX.
- branch_count  out  32  resolved branches and jumps.
- mispredict_count  out  32  mispredictions.

## Operation
- BTB entry fields: valid, tag, target, ctr[1:0]. Index = pc[IDX_W+1:2].
- hit = valid[idx(if_pc)] & tag match.
- pred_taken by mode:
  - 00: 0.
  - 10: 0.
  - 01: hit.
  - 11: hit & ctr[1].
- mispredict = ex_valid & (ex_pred_taken != ex_taken | (ex_taken & ex_pred_target != ex_target)).
- Correction PC:
  - Taken: ex_target.
  - Not taken, mode 10: ex_pc+8 (the delay-slot instruction is retained).
  - Not taken, other modes: ex_pc+4.
- next_pc priority: mispredict → correction PC; else pred_taken → pred_target; else if_pc+4.
- flush_if = mispredict.
- flush_id = mispredict & (mode != 10). In delay-slot mode the ID instruction always completes.
- BTB update happens at the clock edge, only when ex_valid and mode ∈ {01, 11}:
  - Taken and hit: ctr saturating increment; target overwritten.
  - Taken and miss: allocate (overwrite) the entry. Set valid=1, tag, target. ctr = 11 for jumps, CTR_INIT for conditional branches.
  - Not taken and hit: ctr saturating decrement (00 floor). Entry stays valid.
  - Not taken and miss: no change.
- Modes 00 and 10 never write the BTB. Contents are retained across mode changes.
- Statistics, counted in all modes and saturating at 32'hFFFF_FFFF:
  - branch_count increments on ex_valid.
  - mispredict_count increments on mispredict.

## Timing
- Reset (rst=0, asynchronous) forces:
  - All valid bits, ctr fields and tags to 0.
  - Both statistics counters to 0.
  - pred_taken = 0, pred_target = 0, flush_if = flush_id = 0, next_pc = if_pc+4 (combinational from if_pc).
- Reset asserted mid-operation discards all history immediately. Release is synchronous to the next rising edge.
- Prediction is combinational: zero-cycle latency from if_pc.
- Flush and redirect are combinational in the same cycle as ex_valid. The PC register and pipeline registers act on them at the next rising edge.
- BTB and counter updates become visible to lookups one cycle after the resolving edge. A same-cycle lookup of the index being updated sees the old contents.
- Statistics reflect a resolution one cycle after ex_valid.
- A mode change takes effect combinationally. A stale ex_pred_taken=1 arriving under mode 10 is handled by the general mispredict rule.
- Aliasing: different PCs with the same index and different tags miss, and allocation overwrites.

## Test plan
- Reset, then mode=00; beq at ex_pc=16 resolves taken to 72 → flush_if=1, flush_id=1, next_pc=72, mispredict_count=1 one cycle later.
- Mode=10; same branch taken → flush_if=1, flush_id=0, next_pc=72. Branch not taken → no flush, next_pc=if_pc+4.
- Mode=11; beq at 60 taken twice, then if_pc=60:
  - First resolution: miss, allocate with ctr=10 and mispredict.
  - Second resolution: ctr=11.
  - Lookup at 60 → pred_taken=1, pred_target=72.
  - After three not-taken resolutions → ctr=00, pred_taken=0.
- Mode=01; j at 76 to 24 resolves → allocated with ctr=11. Next fetch at 76 → next_pc=24. Resolution with matching pred → no flush.
- Aliasing with ENTRIES=16: PC 8 allocated, then PC 72 (same index, different tag) allocated → lookup at 8 misses.
- Drive ex_valid every cycle with counters preloaded to 32'hFFFF_FFFE → saturate at FFFF_FFFF. Assert rst=0 mid-run → outputs and counters clear asynchronously and the BTB misses for all PCs.
